// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Ports: clock/reset_n, req_valid/req_data/req_ready from producers, tx_bit/tx_data_byte/tx_done to the transmitter, busy/grant_idx/timeout_err status.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_bit,
  output logic [7:0]           tx_data_byte,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_grant;
  logic [WD_W-1:0]      r_wd;
  logic [NUM_REQ-1:0]   r_ready;
  logic                 r_txbit;
  logic [7:0]           r_byte;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_any;
  logic [IDX_W-1:0]     w_win;
  logic [7:0]           w_byte;
  logic [IDX_W-1:0]     w_ptr_nxt;

  // Lowest valid index overall, then overridden by the lowest
  // valid index at or above ptr: that is the circular search.
  always_comb begin
    w_win  = '0;
    w_byte = 8'h00;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_win  = IDX_W'(i);
        w_byte = req_data[8*i +: 8];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i >= int'(r_ptr)) begin
        w_win  = IDX_W'(i);
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  assign w_any     = |req_valid;
  assign w_ptr_nxt = (r_grant == IDX_W'(NUM_REQ - 1)) ?
                     '0 : r_grant + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_wd    <= '0;
      r_ready <= '0;
      r_txbit <= 1'b0;
      r_byte  <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= '0;
      r_txbit <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_START;
            r_byte  <= w_byte;
            r_grant <= w_win;
            r_ready <= NUM_REQ'(1) << w_win;
            r_txbit <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_wd    <= '0;
        end
        S_WAIT: begin
          if (tx_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_nxt;
          end else if (r_wd == WD_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            r_err   <= 1'b1;
          end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign tx_bit       = r_txbit;
  assign tx_data_byte = r_byte;
  assign busy         = r_busy;
  assign grant_idx    = r_grant;
  assign timeout_err  = r_err;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `transmitter` instance between `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and drives the transmitter's start strobe and data byte. It then waits for `tx_done` before granting again, with a watchdog that aborts a stuck transfer. It sits directly in front of `transmitter`; the receiver path is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, 2: width of the grant index. Must equal ceil(log2(`NUM_REQ`)).
- `TIMEOUT_CYCLES`, 65535: maximum clocks spent in WAIT_DONE before abort. Minimum 1.
- `clock`  in  1  single system clock. All logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  bit i high means requester i has a byte pending. It is held until `req_ready[i]` is seen.
- `req_data`  in  8*`NUM_REQ`  byte of requester i at bits [8i+7:8i]. It is held stable while `req_valid[i]` is high.
- `req_ready`  out  `NUM_REQ`  one-cycle pulse on bit i when requester i's byte is accepted.
- `tx_bit`  out  1  start strobe to `transmitter.tx_bit`.
- `tx_data_byte`  out  8  byte to `transmitter.tx_data_byte`.
- `tx_done`  in  1  completion pulse from `transmitter.tx_done`.
- `busy`  out  1  high in any state other than IDLE.
- `grant_idx`  out  `IDX_W`  index of the requester currently being served.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
- **States:** IDLE, START, WAIT_DONE.
- **Reset values:**
  - state = IDLE.
  - `req_ready` = 0, `tx_bit` = 0, `tx_data_byte` = 8'h00.
  - `busy` = 0, `grant_idx` = 0, `timeout_err` = 0.
  - round-robin pointer `ptr` = 0, watchdog counter = 0.
- **IDLE:**
  - Winner w is the first i with `req_valid[i]` high, searching `ptr`, `ptr`+1, ... modulo `NUM_REQ`.
  - If no bit is set, stay in IDLE.
  - Otherwise, on the next edge, go to START and register `tx_data_byte` = byte w and `grant_idx` = w.
  - On that same edge, set `req_ready[w]` = 1 and `tx_bit` = 1.
- **START:**
  - Lasts exactly one cycle; `tx_bit` and `req_ready[w]` are high only during this cycle.
  - Next state is WAIT_DONE, with `tx_bit` = 0, `req_ready` = 0 and watchdog cleared to 0.
- **WAIT_DONE:**
  - `tx_data_byte` is held constant.
  - Watchdog increments by 1 each cycle and saturates; it does not wrap.
  - If `tx_done` is sampled high: go to IDLE and set `ptr` = (w+1) mod `NUM_REQ`.
  - Otherwise, if the watchdog reaches `TIMEOUT_CYCLES`-1: go to IDLE, pulse `timeout_err` for one cycle, and advance `ptr` the same way.
  - If both hold in the same cycle, `tx_done` wins and there is no error pulse.
- **Rules:**
  - Requesters that are not granted see no `req_ready`. A requester may drop `req_valid` before being granted; nothing is latched.
  - `tx_done` sampled in IDLE or START is ignored.
  - `req_valid` changing during START or WAIT_DONE has no effect until the next IDLE.
- **Reset mid-operation:** all registers return to their reset values immediately. An in-flight byte is abandoned with no `req_ready` re-issue, and `ptr` returns to 0.

## Timing
- **Accept latency:** `req_valid` high in IDLE at cycle N gives `req_ready` and `tx_bit` high in cycle N+1.
- **Minimum spacing:** IDLE always lasts at least one cycle between transfers, so back-to-back starts are at least 3 cycles apart plus the transmitter's time to `tx_done`.
- **Turnaround:** `tx_done` high in cycle M gives IDLE in M+1, and the next `tx_bit` in M+2 at the earliest.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,...,`NUM_REQ`-1,0,... with no repeats.
- **Output timing:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single request:** reset, then `req_valid`=4'b0001 with byte 8'hAB. Expect `req_ready`=4'b0001 and `tx_bit` for exactly 1 cycle, one cycle after valid, with `tx_data_byte`=8'hAB and `grant_idx`=0. Loop back into `transmitter`/`receiver` and expect 8'hAB received.
- **Round-robin fairness:** all four requesters valid with bytes 8'h10, 8'h21, 8'h32, 8'h43, re-asserting after each grant. Expect grant order 0,1,2,3,0 and transmitted bytes 10,21,32,43,10.
- **Pointer rotation:** `ptr`=2 after serving requester 1, then requesters 0 and 3 valid. Expect 3 granted first, then 0.
- **Watchdog:** `TIMEOUT_CYCLES`=16, `tx_done` tied low. Expect `timeout_err` pulsed exactly 16 cycles after START and a return to IDLE. Repeat with `tx_done` pulsed on the 16th cycle and expect no `timeout_err`.
- **Async reset mid-transfer:** assert `reset_n`=0 in WAIT_DONE between edges. Expect `busy`, `tx_bit` and `req_ready` to be 0 immediately, not at the next edge, and `grant_idx`=0. After release with requester 2 valid, expect it granted normally.
- **Spurious inputs:** `tx_done` pulsed while in IDLE with no requests. Expect no state change. A requester that drops `req_valid` before being granted must receive no `req_ready`.
